// File: rtl/game_pkg.sv
// Shared types and constants for the Chicken Cha-Cha-Cha game datapath and control.
package game_pkg;

  localparam int unsigned KIND_W_DEF = 3;
  localparam int unsigned LFSR_W     = 8;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef logic [KIND_W_DEF-1:0] kind_t;

  typedef enum logic [1:0] {
    ST_GEN  = 2'b00,
    ST_PLAY = 2'b01,
    ST_WON  = 2'b10
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tile_board_datapath_btn_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse for a panel button.
module btn_sync_edge (
  input  logic CLK,
  input  logic RSTn,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, sync3;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      pulse <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/tile_board_datapath.sv
// Game datapath: random tile board generation, player ring position, card match and score.
module tile_board_datapath
  import game_pkg::*;
#(
  parameter int unsigned      NUM_TILES = 12,
  parameter int unsigned      KIND_W    = KIND_W_DEF,
  parameter int unsigned      WIN_STEPS = 24,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         new_game,
  input  logic                         btn,
  input  logic [KIND_W-1:0]            sel,
  input  logic                         A,
  input  logic                         B,
  output logic                         c,
  output logic                         key,
  output logic                         go,
  output logic                         win,
  output logic [$clog2(NUM_TILES)-1:0] pos
);

  localparam int unsigned POS_W   = $clog2(NUM_TILES);
  localparam int unsigned SCORE_W = $clog2(WIN_STEPS + 1);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [POS_W-1:0]    idx_q, idx_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [POS_W-1:0]    pos_d;
  logic                c_d, go_d, win_d;
  logic                b_prev_q;
  logic                b_rise;
  logic                wr_en;
  logic [KIND_W-1:0]   cand;
  logic [POS_W-1:0]    prev_idx;
  logic [POS_W-1:0]    nxt_pos;
  logic                last_idx;
  logic [SCORE_W-1:0]  score_inc;
  logic [KIND_W-1:0]   board [NUM_TILES];

  btn_sync_edge u_btn (
    .CLK  (CLK),
    .RSTn (RSTn),
    .btn  (btn),
    .pulse(key)
  );

  assign cand      = lfsr_q[KIND_W-1:0];
  assign b_rise    = B & ~b_prev_q;
  assign last_idx  = (idx_q == POS_W'(NUM_TILES - 1));
  assign prev_idx  = idx_q - POS_W'(1);
  assign nxt_pos   = (pos == POS_W'(NUM_TILES - 1)) ? '0 : pos + POS_W'(1);
  assign score_inc = score_q + SCORE_W'(1);

  // Free-running random source, untouched by new_game
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  // Board storage has no reset; it is fully rewritten before c rises
  always_ff @(posedge CLK) begin
    if (wr_en) board[idx_q] <= cand;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_GEN;
      idx_q    <= '0;
      score_q  <= '0;
      pos      <= '0;
      c        <= 1'b0;
      go       <= 1'b0;
      win      <= 1'b0;
      b_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      score_q  <= score_d;
      pos      <= pos_d;
      c        <= c_d;
      go       <= go_d;
      win      <= win_d;
      b_prev_q <= B;
    end
  end

  // Next-state and datapath updates; new_game overrides everything
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    score_d = score_q;
    pos_d   = pos;
    c_d     = (state_q != ST_GEN);
    go_d    = go;
    win_d   = win;
    wr_en   = 1'b0;

    if (new_game) begin
      state_d = ST_GEN;
      idx_d   = '0;
      score_d = '0;
      pos_d   = '0;
      c_d     = 1'b0;
      go_d    = 1'b0;
      win_d   = 1'b0;
    end else begin
      case (state_q)
        ST_GEN: begin
          // Reject a candidate equal to its left neighbour; the last tile also closes the ring
          if (idx_q == '0) begin
            wr_en = 1'b1;
          end else if ((cand != board[prev_idx]) && !(last_idx && (cand == board[0]))) begin
            wr_en = 1'b1;
          end
          if (wr_en) begin
            if (last_idx) begin
              state_d = ST_PLAY;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + POS_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (b_rise) begin
            pos_d   = nxt_pos;
            score_d = score_inc;
            go_d    = 1'b0;
            if (score_inc == SCORE_W'(WIN_STEPS)) begin
              win_d   = 1'b1;
              state_d = ST_WON;
            end
          end else if (A && key) begin
            go_d = (sel == board[nxt_pos]);
          end
        end
        ST_WON: begin
        end
        default: begin
          state_d = ST_GEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_board_datapath.sv
// Scoreboarded random test of tile_board_datapath against a game-rule reference model.
module tb_tile_board_datapath;
  import game_pkg::*;

  localparam int NT = 12;
  localparam int WS = 24;
  localparam int M_GEN = 0, M_PLAY = 1, M_WON = 2;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       new_game = 1'b0;
  logic       btn = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       c, key, go, win;
  logic [3:0] pos;

  always #5 CLK = ~CLK;

  tile_board_datapath dut (
    .CLK(CLK), .RSTn(RSTn), .new_game(new_game), .btn(btn), .sel(sel),
    .A(A), .B(B), .c(c), .key(key), .go(go), .win(win), .pos(pos)
  );

  int cyc;
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic       key;
    logic       c;
    logic       go;
    logic       win;
    logic [3:0] pos;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  kind_t mb [NT];
  int    m_pos, m_score, m_mode;
  logic  m_go, m_win, m_c;

  // LFSR value m clock edges after reset release, stepped from the seed
  function automatic logic [7:0] lfsr_at(input int m);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < m; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  task automatic push(input int t, input logic k);
    exp_t e;
    e.cyc = t; e.key = k; e.c = m_c; e.go = m_go; e.win = m_win; e.pos = 4'(m_pos);
    exp_q.push_back(e);
  endtask

  // Board built from the rules; returns the cycle at which c is first seen high
  task automatic model_gen(input int s, output int ready);
    logic [7:0] l;
    kind_t      cand;
    int         idx, m;
    bit         ok;
    l = lfsr_at(s); idx = 0; m = s; ready = s + 5000;
    for (int it = 0; it < 5000; it++) begin
      cand = l[2:0];
      ok = (idx == 0) || ((cand != mb[idx-1]) && !((idx == NT-1) && (cand == mb[0])));
      if (ok) begin
        mb[idx] = cand;
        if (idx == NT-1) begin
          ready = m + 2;
          break;
        end
        idx++;
      end
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      m++;
    end
  endtask

  task automatic check_board();
    for (int i = 0; i < NT; i++) begin
      n_cmp++;
      if (dut.board[i] !== mb[i]) begin
        n_err++;
        $display("FAIL board[%0d]: got %0d want %0d", i, dut.board[i], mb[i]);
      end
    end
  endtask

  task automatic check_score();
    n_cmp++;
    if (dut.score_q !== 5'(m_score)) begin
      n_err++;
      $display("FAIL score @%0d: got %0d want %0d", cyc, dut.score_q, m_score);
    end
  endtask

  task automatic advance();
    m_pos   = (m_pos + 1) % NT;
    m_score = m_score + 1;
    m_go    = 1'b0;
    if (m_score == WS) begin
      m_win  = 1'b1;
      m_mode = M_WON;
    end
  endtask

  task automatic press(input bit a, input logic [2:0] s, input int hold);
    int   n;
    logic ng;
    n = cyc; A = a; sel = s; btn = 1'b1;
    push(n + 3, 1'b1);
    if (m_mode == M_PLAY && a) begin
      ng = (s == mb[(m_pos + 1) % NT]);
      if (ng != m_go) begin
        m_go = ng;
        push(n + 4, 1'b0);
      end
    end
    repeat (hold) @(negedge CLK);
    btn = 1'b0; A = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic bpulse(input int len);
    int n;
    n = cyc; B = 1'b1;
    if (m_mode == M_PLAY) begin
      advance();
      push(n + 1, 1'b0);
    end
    repeat (len) @(negedge CLK);
    B = 1'b0;
    @(negedge CLK);
  endtask

  task automatic key_and_b(input bit a, input logic [2:0] s);
    int n;
    n = cyc; A = a; sel = s; btn = 1'b1;
    push(n + 3, 1'b1);
    repeat (3) @(negedge CLK);
    B = 1'b1;
    if (m_mode == M_PLAY) begin
      advance();
      push(n + 4, 1'b0);
    end
    @(negedge CLK);
    B = 1'b0;
    repeat (2) @(negedge CLK);
    btn = 1'b0; A = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic newgame(input bit with_b);
    int n, ready;
    n = cyc; new_game = 1'b1; B = with_b;
    m_mode = M_GEN; m_c = 1'b0; m_go = 1'b0; m_win = 1'b0; m_pos = 0; m_score = 0;
    push(n + 1, 1'b0);
    @(negedge CLK);
    new_game = 1'b0; B = 1'b0;
    check_score();
    model_gen(n + 1, ready);
    m_c = 1'b1;
    push(ready, 1'b0);
    while (cyc < ready + 1) @(negedge CLK);
    m_mode = M_PLAY;
    check_board();
  endtask

  // Monitor: every output change or key pulse consumes one expected event
  initial begin
    logic [6:0] prev, obs;
    exp_t       e;
    prev = '0;
    wait (RSTn);
    forever begin
      @(negedge CLK);
      obs = {c, go, win, pos};
      if (key || (obs !== prev)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event @%0d: key=%b c=%b go=%b win=%b pos=%0d", cyc, key, c, go, win, pos);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.key !== key || e.c !== c || e.go !== go || e.win !== win || e.pos !== pos) begin
            n_err++;
            $display("FAIL event: got cyc=%0d key=%b c=%b go=%b win=%b pos=%0d, want cyc=%0d key=%b c=%b go=%b win=%b pos=%0d",
                     cyc, key, c, go, win, pos, e.cyc, e.key, e.c, e.go, e.win, e.pos);
          end
        end
      end
      prev = obs;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ready, r;
    logic [2:0] s;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({c, key, go, win, pos} !== 8'b0) begin
      n_err++;
      $display("FAIL reset: got c=%b key=%b go=%b win=%b pos=%0d want all 0", c, key, go, win, pos);
    end

    m_mode = M_GEN; m_pos = 0; m_score = 0; m_go = 1'b0; m_win = 1'b0; m_c = 1'b0;
    RSTn = 1'b1;
    // Button pressed during generation still pulses key
    btn = 1'b1; A = 1'b1;
    push(3, 1'b1);
    model_gen(0, ready);
    m_c = 1'b1;
    push(ready, 1'b0);
    repeat (5) @(negedge CLK);
    btn = 1'b0; A = 1'b0;
    while (cyc < ready + 1) @(negedge CLK);
    m_mode = M_PLAY;
    check_board();
    check_score();

    press(1'b1, mb[1], 5);
    press(1'b1, mb[1] + 3'd1, 5);
    press(1'b1, mb[1], 5);
    press(1'b0, mb[1] + 3'd2, 5);
    bpulse(4);
    check_score();
    key_and_b(1'b1, mb[(m_pos + 1) % NT]);

    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        s = ($urandom_range(0, 1) == 1) ? mb[(m_pos + 1) % NT] : 3'($urandom_range(0, 7));
        press(1'($urandom_range(0, 1)), s, $urandom_range(4, 6));
      end else if (r < 9) begin
        bpulse($urandom_range(1, 4));
      end else begin
        key_and_b(1'($urandom_range(0, 1)), mb[(m_pos + 1) % NT]);
      end
    end
    while (!m_win) bpulse($urandom_range(1, 2));
    check_score();

    bpulse(2);
    press(1'b1, mb[(m_pos + 1) % NT], 5);
    key_and_b(1'b1, 3'($urandom_range(0, 7)));
    check_score();

    newgame(1'b0);
    repeat (5) bpulse(1);
    check_score();
    newgame(1'b1);

    repeat (11) bpulse(1);
    bpulse(1);
    check_score();
    press(1'b1, mb[(m_pos + 1) % NT], 5);

    repeat (10) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_events: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
